// File: rtl/union_lane_packer.sv
// union_lane_packer
//   Packs a byte stream into little-endian words with a per-lane byte-enable
//   mask. One accumulator word plus one output register, so byte intake keeps
//   going while a finished word waits for the consumer.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_byte / in_last are valid
//   in_ready   packer can take a byte this cycle (depends only on acc_done)
//   in_byte    byte payload
//   in_last    byte closes the current word early
//   out_valid  out_word / out_be hold a complete word
//   out_ready  consumer takes the word this cycle
//   out_word   assembled word, lane k = bits [k*LANE_W +: LANE_W]
//   out_be     lane-valid mask, bit k set if lane k was written
module union_lane_packer #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANE_W-1:0]       in_byte,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_word,
  output logic [LANES-1:0]        out_be
);

  localparam int WORD_W = LANES * LANE_W;
  localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;

  logic [WORD_W-1:0] acc_data;
  logic [LANES-1:0]  acc_be;
  logic [CNT_W-1:0]  acc_cnt;
  logic              acc_done;

  logic [WORD_W-1:0] acc_data_nxt;
  logic [LANES-1:0]  acc_be_nxt;
  logic [WORD_W-1:0] load_data;
  logic [LANES-1:0]  load_be;

  logic accept;
  logic slot_free;
  logic completes;
  logic out_xfer;

  assign in_ready  = !acc_done;
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;
  assign out_xfer  = out_valid && out_ready;
  assign completes = in_last || (acc_cnt == CNT_W'(LANES - 1));

  // Accumulator contents after writing in_byte into lane acc_cnt.
  always_comb begin
    acc_data_nxt = acc_data;
    acc_be_nxt   = acc_be;
    for (int k = 0; k < LANES; k++) begin
      if (acc_cnt == CNT_W'(k)) begin
        acc_data_nxt[k*LANE_W +: LANE_W] = in_byte;
        acc_be_nxt[k]                    = 1'b1;
      end
    end
  end

  // Word headed for the output register: a parked word takes priority over
  // the one being completed this cycle (intake is stalled while parked).
  // Unwritten lanes are zeroed explicitly rather than trusting the clear.
  always_comb begin
    load_data = acc_done ? acc_data : acc_data_nxt;
    load_be   = acc_done ? acc_be   : acc_be_nxt;
    for (int k = 0; k < LANES; k++) begin
      if (!load_be[k]) begin
        load_data[k*LANE_W +: LANE_W] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_data  <= '0;
      acc_be    <= '0;
      acc_cnt   <= '0;
      acc_done  <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_be    <= '0;
    end else if ((acc_done || (accept && completes)) && slot_free) begin
      out_word  <= load_data;
      out_be    <= load_be;
      out_valid <= 1'b1;
      acc_data  <= '0;
      acc_be    <= '0;
      acc_cnt   <= '0;
      acc_done  <= 1'b0;
    end else begin
      if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        acc_data <= acc_data_nxt;
        acc_be   <= acc_be_nxt;
        if (completes) begin
          // Output slot busy: park the finished word and stall intake.
          acc_done <= 1'b1;
        end else begin
          acc_cnt <= acc_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_union_lane_packer.sv
module tb_union_lane_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [3:0]  out_be;

  union_lane_packer #(.LANES(4), .LANE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_be    (out_be)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic        last;
    logic        push;
    logic [31:0] w;
    logic [3:0]  be;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  be;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] w, input logic [3:0] be);
    exp_t e;
    e.w  = w;
    e.be = be;
    sb.push_back(e);
  endtask

  // Drive one byte, hold it until accepted (bounded), return at edge + 1.
  task automatic send(input logic [7:0] b, input logic last);
    int waited;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: byte %h never accepted", b);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every word transfer is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got word %h be %b with nothing expected", out_word, out_be);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_word", out_word, e.w);
        chk("sb_be", {28'b0, out_be}, {28'b0, e.be});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{8'hEF, 1'b0, 1'b0, 32'h0,        4'h0};
    vecs[1]  = '{8'hBE, 1'b0, 1'b0, 32'h0,        4'h0};
    vecs[2]  = '{8'hAD, 1'b0, 1'b0, 32'h0,        4'h0};
    vecs[3]  = '{8'hDE, 1'b0, 1'b1, 32'hDEADBEEF, 4'b1111};
    vecs[4]  = '{8'hAA, 1'b0, 1'b0, 32'h0,        4'h0};
    vecs[5]  = '{8'hBB, 1'b1, 1'b1, 32'h0000BBAA, 4'b0011};
    vecs[6]  = '{8'h11, 1'b0, 1'b0, 32'h0,        4'h0};
    vecs[7]  = '{8'h22, 1'b0, 1'b0, 32'h0,        4'h0};
    vecs[8]  = '{8'h33, 1'b0, 1'b0, 32'h0,        4'h0};
    vecs[9]  = '{8'h44, 1'b1, 1'b1, 32'h44332211, 4'b1111};
    vecs[10] = '{8'h55, 1'b1, 1'b1, 32'h00000055, 4'b0001};
    vecs[11] = '{8'h01, 1'b0, 1'b0, 32'h0,        4'h0};
    vecs[12] = '{8'h03, 1'b1, 1'b1, 32'h00000301, 4'b0011};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_word", out_word, 32'h0);
    chk("rst_out_be", {28'b0, out_be}, 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    // in_last without in_valid must not flush anything.
    in_last = 1'b1;
    cycle();
    cycle();
    in_last = 1'b0;
    chk("idle_last_ignored", {31'b0, out_valid}, 32'd0);

    // Table: with out_ready held high, out_valid right after each edge must
    // equal "this byte completed a word".
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].push) push_exp(vecs[i].w, vecs[i].be);
      send(vecs[i].b, vecs[i].last);
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].push});
      if (vecs[i].push) begin
        chk($sformatf("vec%0d_out_word", i), out_word, vecs[i].w);
        chk($sformatf("vec%0d_out_be", i), {28'b0, out_be}, {28'b0, vecs[i].be});
      end
      chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
    end

    // Streaming: 16 back-to-back bytes, one word every 4 cycles.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'h80 + 8'(i);
      if (i % 4 == 3) push_exp({b, b - 8'd1, b - 8'd2, b - 8'd3}, 4'b1111);
      send(b, 1'b0);
      chk($sformatf("stream%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
      chk($sformatf("stream%0d_out_valid", i), {31'b0, out_valid}, {31'b0, (i % 4 == 3)});
    end
    repeat (2) cycle();

    // Backpressure: two words buffered, then intake stalls.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) push_exp(32'h03020100, 4'b1111);
      if (i == 7) push_exp(32'h07060504, 4'b1111);
      send(8'(i), 1'b0);
      chk($sformatf("bp%0d_in_ready", i), {31'b0, in_ready}, {31'b0, (i != 7)});
    end
    chk("bp_out_word", out_word, 32'h03020100);
    repeat (3) cycle();
    chk("bp_hold_word", out_word, 32'h03020100);
    chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_hold_stall", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    cycle();
    chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
    chk("bp_second_word", out_word, 32'h07060504);
    chk("bp_second_valid", {31'b0, out_valid}, 32'd1);
    cycle();
    chk("bp_drained", {31'b0, out_valid}, 32'd0);
    chk("bp_sb_empty", sb.size(), 32'd0);

    // Reset mid-word with a pending output word; neither may survive.
    out_ready = 1'b0;
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    send(8'h64, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_out_word", out_word, 32'h0);
    cycle();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b0);
    send(8'h0C, 1'b0);
    push_exp(32'h0D0C0B0A, 4'b1111);
    send(8'h0D, 1'b0);
    chk("post_rst_word", out_word, 32'h0D0C0B0A);
    chk("post_rst_be", {28'b0, out_be}, 32'hF);
    repeat (3) cycle();
    chk("final_sb_empty", sb.size(), 32'd0);
    chk("final_idle", {31'b0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/union_lane_packer.md
# union_lane_packer

Byte-to-word packing stage that sits directly upstream of the packed-union data register (32-bit word view / 4×8-bit byte view). It accepts a byte stream on a valid/ready handshake, assembles bytes into 32-bit words in little-endian lane order, and presents each word with a per-lane byte-enable mask. The consumer uses the mask to issue either a full-word write or individual byte-lane writes. A one-word accumulator plus a one-word output register let byte intake continue while a finished word waits for the consumer.

## Interface
- LANES, 4, number of byte lanes per word
- LANE_W, 8, bits per lane; word width = LANES*LANE_W (32)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  in_byte/in_last are valid
- in_ready  output  1  packer can accept a byte this cycle
- in_byte  input  LANE_W  byte payload
- in_last  input  1  this byte closes the current word (partial flush)
- out_valid  output  1  out_word/out_be hold a complete word
- out_ready  input  1  consumer takes the word this cycle
- out_word  output  LANES*LANE_W  assembled word; lane k = bits [8k+7:8k]
- out_be  output  LANES  lane-valid mask; bit k set if lane k was written

## Operation
- Byte accepted when in_valid && in_ready. Word transferred when out_valid && out_ready.
- Accumulator state: acc_data, acc_be, lane index acc_cnt (0..LANES-1), acc_done flag.
- On byte accept: acc_data lane acc_cnt <= in_byte, acc_be[acc_cnt] <= 1, acc_cnt increments.
- A word completes when the accepted byte is in lane LANES-1, or when in_last=1 (any lane).
- Completion when the output slot is free (out_valid=0, or out_ready=1 in the same cycle):
  - out_word <= completed data, with unwritten lanes forced to 0.
  - out_be <= completed mask, out_valid <= 1.
  - Accumulator clears: acc_cnt=0, acc_be=0, acc_data=0.
- Completion when the output slot is busy: set acc_done. in_ready = !acc_done, so intake stalls.
- While acc_done=1 and the slot frees (out_valid=0, or out_ready=1): move acc to the output register, clear the accumulator and acc_done.
- in_ready is a combinational function of acc_done only. It does not depend on in_valid or out_ready.
- in_last=1 with in_valid=0 is ignored. There is no flush of an empty accumulator, and out_be is never 0 when out_valid=1.
- out_word and out_be stay stable while out_valid=1 and out_ready=0.
- Words leave strictly in acceptance order. No byte is dropped or duplicated.

## Timing
- Reset (async assert, sync release), all values 0: out_valid, out_word, out_be, acc_data, acc_be, acc_cnt, acc_done. in_ready=1 during and after reset.
- Latency: the completing byte accepted at edge N gives out_valid=1 after edge N (visible in cycle N+1) when the slot is free.
- Throughput: 1 byte/cycle sustained with out_ready=1. One word every LANES cycles, no bubbles.
- Backpressure capacity: one word in the output register plus one completed word in the accumulator, i.e. 2*LANES bytes before in_ready=0.
- Simultaneous out transfer and completing byte in the same cycle: the new word loads the output register directly. No bubble, acc_done stays 0.
- Simultaneous out transfer and acc_done=1: the accumulator moves to output. in_ready returns to 1 the next cycle.
- Reset mid-word: the partial accumulator and any pending output word are discarded. After release the first byte goes to lane 0.

## Test plan
- Full word: bytes EF,BE,AD,DE on consecutive cycles, out_ready=1 -> one cycle later out_valid=1, out_word=32'hDEADBEEF, out_be=4'b1111.
- Partial flush: AA, then BB with in_last=1 -> out_word=32'h0000BBAA, out_be=4'b0011. The next byte lands in lane 0.
- Backpressure: out_ready=0, stream bytes 00..07.
  - in_ready drops after byte 07; out_word=32'h03020100 held stable.
  - Raise out_ready -> 32'h03020100 then 32'h07060504, in order.
  - in_ready returns to 1 one cycle after the first transfer.
- Streaming: 16 bytes back-to-back with out_ready=1 -> 4 words, one every 4 cycles; in_ready never deasserts.
- in_last on lane 3: bytes 11,22,33,44 with in_last on 44 -> 32'h44332211, be=4'b1111, exactly one word (no extra empty word).
- Reset mid-word: accept 01,02, assert rst_n=0 -> out_valid=0, in_ready=1. After release, 0A,0B,0C,0D -> 32'h0D0C0B0A with no residue of 01,02.
